// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: single-outstanding 16-bit fetch with valid/ready
// delivery, redirect handling and a running count of accepted instructions.
module cpu_fetch_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [2:0]        cpu_opcode,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [31:0]       instr_count
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ~ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_target;
    logic              handshake;

    assign pc_inc          = pc + ADDR_W'(2);
    assign redirect_target = redirect_pc & ~ADDR_W'(1);
    assign handshake       = (state == HOLD) && instr_valid && instr_ready;

    // The read strobe must react within the same cycle to a handshake,
    // a redirect or reset, so it is decoded combinationally from state.
    always_comb begin
        imem_rd_en = rst_n && !redirect_valid && ((state == FETCH) || handshake);
        imem_addr  = (state == HOLD) ? pc_inc : pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= START_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            cpu_opcode  <= '0;
            instr_pc    <= START_PC;
            instr_count <= '0;
        end else begin
            if (handshake)
                instr_count <= instr_count + 32'd1;

            // A redirect wins over every state; any read in flight is dropped.
            if (redirect_valid) begin
                pc          <= redirect_target;
                instr_valid <= 1'b0;
                state       <= FETCH;
            end else begin
                case (state)
                    FETCH: state <= WAIT;
                    WAIT: begin
                        instr       <= imem_rdata;
                        cpu_opcode  <= imem_rdata[15:13];
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            pc          <= pc_inc;
                            instr_valid <= 1'b0;
                            state       <= WAIT;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: directed scenarios plus a randomized
// run compared against a transaction-level model of the fetch stream.
module tb_cpu_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [2:0]  cpu_opcode;
    logic [15:0] instr_pc;
    logic [31:0] instr_count;

    int tests = 0;
    int fails = 0;

    // Model: pending fetch, read in flight, or instruction being offered.
    logic        m_need, m_fl, m_valid;
    logic [15:0] m_pc, m_fl_addr, m_instr, m_ipc;
    logic [31:0] m_count;
    logic        exp_rd, act_rd;
    logic [15:0] exp_addr, act_addr;

    cpu_fetch_unit #(.ADDR_W(16), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .cpu_opcode(cpu_opcode), .instr_pc(instr_pc),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h2005;
        return (a * 16'h9E37) ^ 16'hC3A5 ^ {a[7:0], a[15:8]};
    endfunction

    // One clock: apply inputs, sample the strobe before the edge, advance the model.
    task automatic drive(input logic rn, input logic rdy, input logic rv, input logic [15:0] rpc);
        logic hs;
        rst_n = rn; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #3;
        act_rd   = imem_rd_en;
        act_addr = imem_addr;
        exp_rd   = rn && !rv && (m_need || (m_valid && rdy));
        exp_addr = m_need ? m_pc : m_pc + 16'd2;
        @(posedge clk);
        #1;
        if (!rn) begin
            m_need = 1'b1; m_fl = 1'b0; m_valid = 1'b0;
            m_pc = RST_PC; m_instr = '0; m_ipc = RST_PC; m_count = '0;
        end else begin
            hs = m_valid && rdy;
            if (hs) m_count = m_count + 32'd1;
            if (rv) begin
                m_pc = rpc & 16'hFFFE; m_valid = 1'b0; m_need = 1'b1; m_fl = 1'b0;
            end else if (m_need) begin
                m_need = 1'b0; m_fl = 1'b1; m_fl_addr = m_pc;
            end else if (m_fl) begin
                m_fl = 1'b0; m_valid = 1'b1; m_instr = mem_word(m_fl_addr); m_ipc = m_fl_addr;
            end else if (hs) begin
                m_pc = m_pc + 16'd2; m_valid = 1'b0; m_fl = 1'b1; m_fl_addr = m_pc;
            end
        end
        imem_rdata = exp_rd ? mem_word(exp_addr) : 16'($urandom);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
            tests++;
            if (act_rd !== 1'b0) begin fails++; $display("FAIL reset_rd: rd=%b want 0", act_rd); end
        end
        tests++;
        if (instr_valid !== 1'b0 || instr !== 16'h0000 || cpu_opcode !== 3'b000) begin
            fails++; $display("FAIL reset_instr: valid=%b instr=%h op=%b want 0/0000/000", instr_valid, instr, cpu_opcode);
        end
        tests++;
        if (instr_pc !== RST_PC || instr_count !== 32'd0) begin
            fails++; $display("FAIL reset_pc_count: pc=%h count=%0d want %h/0", instr_pc, instr_count, RST_PC);
        end
    endtask

    task automatic test_first_fetch();
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== 16'h0000) begin
            fails++; $display("FAIL first_rd: rd=%b addr=%h want 1/0000", act_rd, act_addr);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b0) begin fails++; $display("FAIL wait_rd: rd=%b want 0", act_rd); end
        tests++;
        if (instr_valid !== 1'b1 || instr !== 16'h2005 || cpu_opcode !== 3'b001 || instr_pc !== 16'h0000) begin
            fails++; $display("FAIL first_instr: valid=%b instr=%h op=%b pc=%h want 1/2005/001/0000",
                              instr_valid, instr, cpu_opcode, instr_pc);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== 16'h0002) begin
            fails++; $display("FAIL second_rd: rd=%b addr=%h want 1/0002", act_rd, act_addr);
        end
        tests++;
        if (instr_valid !== 1'b0 || instr_count !== 32'd1) begin
            fails++; $display("FAIL first_accept: valid=%b count=%0d want 0/1", instr_valid, instr_count);
        end
    endtask

    task automatic test_stall();
        logic [15:0] s_instr, s_pc;
        logic [31:0] s_count;
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0002 || instr !== mem_word(16'h0002)) begin
            fails++; $display("FAIL stall_entry: valid=%b pc=%h instr=%h want 1/0002/%h",
                              instr_valid, instr_pc, instr, mem_word(16'h0002));
        end
        s_instr = instr; s_pc = instr_pc; s_count = instr_count;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0);
            tests++;
            if (act_rd !== 1'b0 || instr_valid !== 1'b1 || instr !== s_instr || instr_pc !== s_pc) begin
                fails++; $display("FAIL stall_hold: rd=%b valid=%b instr=%h pc=%h want 0/1/%h/%h",
                                  act_rd, instr_valid, instr, instr_pc, s_instr, s_pc);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== s_pc + 16'd2) begin
            fails++; $display("FAIL stall_release_rd: rd=%b addr=%h want 1/%h", act_rd, act_addr, s_pc + 16'd2);
        end
        tests++;
        if (instr_count !== s_count + 32'd1 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL stall_release_cnt: count=%0d valid=%b want %0d/0", instr_count, instr_valid, s_count + 32'd1);
        end
    endtask

    task automatic test_redirect_wait();
        logic [15:0] s_instr;
        s_instr = instr;
        drive(1'b1, 1'b0, 1'b1, 16'h0041);
        tests++;
        if (act_rd !== 1'b0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL redir_wait: rd=%b valid=%b want 0/0", act_rd, instr_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== 16'h0040) begin
            fails++; $display("FAIL redir_wait_rd: rd=%b addr=%h want 1/0040", act_rd, act_addr);
        end
        tests++;
        if (instr !== s_instr || instr_valid !== 1'b0) begin
            fails++; $display("FAIL redir_wait_drop: instr=%h valid=%b want %h/0", instr, instr_valid, s_instr);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== mem_word(16'h0040)) begin
            fails++; $display("FAIL redir_wait_instr: valid=%b pc=%h instr=%h want 1/0040/%h",
                              instr_valid, instr_pc, instr, mem_word(16'h0040));
        end
    endtask

    task automatic test_redirect_handshake();
        logic [31:0] s_count;
        s_count = instr_count;
        drive(1'b1, 1'b1, 1'b1, 16'h0100);
        tests++;
        if (act_rd !== 1'b0 || instr_count !== s_count + 32'd1 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL redir_hs: rd=%b count=%0d valid=%b want 0/%0d/0",
                              act_rd, instr_count, instr_valid, s_count + 32'd1);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== 16'h0100) begin
            fails++; $display("FAIL redir_hs_rd: rd=%b addr=%h want 1/0100", act_rd, act_addr);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 1'b1, 16'hFFFE);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== 16'hFFFE) begin
            fails++; $display("FAIL wrap_fetch: rd=%b addr=%h want 1/fffe", act_rd, act_addr);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== 16'h0000) begin
            fails++; $display("FAIL wrap_next: rd=%b addr=%h want 1/0000", act_rd, act_addr);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'h2005) begin
            fails++; $display("FAIL wrap_instr: valid=%b pc=%h instr=%h want 1/0000/2005", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] s_count;
        s_count = instr_count;
        for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (instr_count !== s_count + 32'd10) begin
            fails++; $display("FAIL ten_accepts: count=%0d want %0d", instr_count, s_count + 32'd10);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        tests++;
        if (instr_count !== 32'd0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL reset_wait: count=%0d valid=%b want 0/0", instr_count, instr_valid);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tests++;
        if (act_rd !== 1'b1 || act_addr !== RST_PC || instr_valid !== 1'b0) begin
            fails++; $display("FAIL reset_wait_rd: rd=%b addr=%h valid=%b want 1/%h/0", act_rd, act_addr, instr_valid, RST_PC);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== RST_PC || instr !== mem_word(RST_PC)) begin
            fails++; $display("FAIL reset_wait_instr: valid=%b pc=%h instr=%h want 1/%h/%h",
                              instr_valid, instr_pc, instr, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_random();
        logic rn, rdy, rv;
        logic [15:0] rpc;
        for (int i = 0; i < 3000; i++) begin
            rn  = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            drive(rn, rdy, rv, rpc);
            tests++;
            if (act_rd !== exp_rd || (exp_rd && act_addr !== exp_addr)) begin
                fails++; $display("FAIL rand_rd[%0d]: rd=%b addr=%h want %b/%h", i, act_rd, act_addr, exp_rd, exp_addr);
            end
            tests++;
            if (instr_valid !== m_valid || instr_count !== m_count) begin
                fails++; $display("FAIL rand_state[%0d]: valid=%b count=%0d want %b/%0d", i, instr_valid, instr_count, m_valid, m_count);
            end
            if (m_valid) begin
                tests++;
                if (instr !== m_instr || cpu_opcode !== m_instr[15:13] || instr_pc !== m_ipc) begin
                    fails++; $display("FAIL rand_instr[%0d]: instr=%h op=%b pc=%h want %h/%b/%h",
                                      i, instr, cpu_opcode, instr_pc, m_instr, m_instr[15:13], m_ipc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
